// File: rtl/stdp_pkg.sv
// Shared widths, FSM state type and saturating helpers for the LIF/STDP sweep scheduler.
package stdp_pkg;

    localparam int V_W  = 8;
    localparam int W_W  = 8;
    localparam int TR_W = 2;

    localparam logic [TR_W-1:0] TRACE_INIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } sched_state_t;

    function automatic logic [W_W-1:0] sat_add(input logic [W_W-1:0] a,
                                               input logic [W_W-1:0] b,
                                               input logic [W_W-1:0] ceil);
        logic [W_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, ceil}) ? ceil : sum[W_W-1:0];
    endfunction

    function automatic logic [W_W-1:0] sat_sub(input logic [W_W-1:0] a,
                                               input logic [W_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    function automatic logic [TR_W-1:0] trace_dec(input logic [TR_W-1:0] t);
        return (t == '0) ? '0 : (t - 1'b1);
    endfunction

endpackage

// File: rtl/lif_stdp_update.sv
// Combinational single-neuron LIF membrane update with optional STDP weight/trace update.
// Trace and weight ports exist only when LIF_SCHED_STDP_EN is defined.
module lif_stdp_update
    import stdp_pkg::*;
#(
    parameter int THRESH = 230,
    parameter int W_MAX  = 127,
    parameter int A_POS  = 2,
    parameter int A_NEG  = 1
) (
    input  logic [V_W-1:0]  v,
    input  logic [W_W-1:0]  w,
    input  logic            pend,
`ifdef LIF_SCHED_STDP_EN
    input  logic [TR_W-1:0] pre_tr,
    input  logic [TR_W-1:0] post_tr,
    output logic [W_W-1:0]  w_next,
    output logic [TR_W-1:0] pre_tr_next,
    output logic [TR_W-1:0] post_tr_next,
`endif
    output logic [V_W-1:0]  v_next,
    output logic            fire
);

    logic [V_W-1:0] leak;
    logic [W_W-1:0] cur;

    // Fire decision uses the membrane before leak; a firing neuron resets to zero.
    always_comb begin
        leak   = (v >> 1) + (v >> 2) + (v >> 3);
        cur    = pend ? w : '0;
        fire   = (v >= V_W'(THRESH));
        v_next = fire ? '0 : sat_add(leak, cur, {V_W{1'b1}});
    end

`ifdef LIF_SCHED_STDP_EN
    logic pot;
    logic dep;

    // Both rules look at the old traces; coincident pot/dep apply their net delta once.
    always_comb begin
        pot    = fire && (pre_tr != '0);
        dep    = pend && (post_tr != '0);
        w_next = w;
        if (pot && dep) begin
            if (A_POS >= A_NEG) w_next = sat_add(w, W_W'(A_POS - A_NEG), W_W'(W_MAX));
            else                w_next = sat_sub(w, W_W'(A_NEG - A_POS));
        end else if (pot) begin
            w_next = sat_add(w, W_W'(A_POS), W_W'(W_MAX));
        end else if (dep) begin
            w_next = sat_sub(w, W_W'(A_NEG));
        end
        pre_tr_next  = pend ? TRACE_INIT : trace_dec(pre_tr);
        post_tr_next = fire ? TRACE_INIT : trace_dec(post_tr);
    end
`endif

endmodule

// File: rtl/lif_sweep_scheduler.sv
// Sweeps N neurons through one shared LIF/STDP datapath, one neuron per clock per tick.
// Define LIF_SCHED_STDP_EN to build plastic weights and traces; otherwise weights stay W_INIT.
module lif_sweep_scheduler
    import stdp_pkg::*;
#(
    parameter int N      = 4,
    parameter int THRESH = 230,
    parameter int W_INIT = 32,
    parameter int W_MAX  = 127,
    parameter int A_POS  = 2,
    parameter int A_NEG  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [N-1:0]         pre_spike,
    input  logic [$clog2(N)-1:0] rd_idx,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         post_spike,
    output logic [V_W-1:0]       rd_state,
    output logic [W_W-1:0]       rd_weight,
    output logic                 tick_miss
);

    localparam int              IW    = $clog2(N);
    localparam logic [IW-1:0]   LAST  = IW'(N - 1);
    localparam logic [W_W-1:0]  W_RST = W_W'((W_INIT > W_MAX) ? W_MAX : W_INIT);

    sched_state_t   state;
    sched_state_t   state_next;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  idx_next;
    logic [N-1:0]   pend;
    logic [N-1:0]   clear_mask;
    logic [V_W-1:0] v_mem [N];
    logic [V_W-1:0] v_next;
    logic [W_W-1:0] w_cur;
    logic           consumed;
    logic           fire;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (tick) begin
                    state_next = SWEEP;
                    idx_next   = '0;
                end
            end
            SWEEP: begin
                busy = 1'b1;
                if (idx == LAST) state_next = DONE;
                else             idx_next   = idx + 1'b1;
            end
            DONE: begin
                done = 1'b1;
                // A tick landing on the done cycle chains straight into the next sweep.
                if (tick) begin
                    state_next = SWEEP;
                    idx_next   = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            tick_miss <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (tick && busy) tick_miss <= 1'b1;
        end
    end

    // A pre-spike arriving on its neuron's own slot is consumed now rather than left pending.
    always_comb begin
        clear_mask = '0;
        if (busy) clear_mask[idx] = 1'b1;
        consumed = pend[idx] | pre_spike[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= '0;
            post_spike <= '0;
            for (int i = 0; i < N; i++) v_mem[i] <= '0;
        end else begin
            pend <= (pend | pre_spike) & ~clear_mask;
            if (busy) begin
                v_mem[idx]      <= v_next;
                post_spike[idx] <= fire;
            end
        end
    end

`ifdef LIF_SCHED_STDP_EN
    logic [W_W-1:0]  w_mem   [N];
    logic [TR_W-1:0] pre_tr  [N];
    logic [TR_W-1:0] post_tr [N];
    logic [W_W-1:0]  w_next;
    logic [TR_W-1:0] pre_tr_next;
    logic [TR_W-1:0] post_tr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                w_mem[i]   <= W_RST;
                pre_tr[i]  <= '0;
                post_tr[i] <= '0;
            end
        end else if (busy) begin
            w_mem[idx]   <= w_next;
            pre_tr[idx]  <= pre_tr_next;
            post_tr[idx] <= post_tr_next;
        end
    end

    assign w_cur     = w_mem[idx];
    assign rd_weight = w_mem[rd_idx];
`else
    assign w_cur     = W_RST;
    assign rd_weight = W_RST;
`endif

    assign rd_state = v_mem[rd_idx];

    lif_stdp_update #(
        .THRESH (THRESH),
        .W_MAX  (W_MAX),
        .A_POS  (A_POS),
        .A_NEG  (A_NEG)
    ) u_update (
        .v            (v_mem[idx]),
        .w            (w_cur),
        .pend         (consumed),
`ifdef LIF_SCHED_STDP_EN
        .pre_tr       (pre_tr[idx]),
        .post_tr      (post_tr[idx]),
        .w_next       (w_next),
        .pre_tr_next  (pre_tr_next),
        .post_tr_next (post_tr_next),
`endif
        .v_next       (v_next),
        .fire         (fire)
    );

endmodule
